// File: rtl/ffra_sched_pkg.sv
// Shared types and constants for the two-requester multiply-accumulate scheduler.
package ffra_sched_pkg;

  localparam int A_W     = 8;
  localparam int CI_W    = 16;
  localparam int O_W     = 16;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic [A_W-1:0]  a;
    logic [A_W-1:0]  b;
    logic [CI_W-1:0] ci;
    logic            acc;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority passes to the loser on accept.
module rr_arb2
  import ffra_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] vld_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  req_id_t prio_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_o = 2'b00;
    case (vld_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else if (accept_i && (gnt_o != 2'b00)) begin
      prio_q <= !gnt_o[1];
    end
  end

endmodule

// File: rtl/ffra_sched.sv
// Scheduler: arbitrates two requesters onto a fixed-latency external datapath and returns results.
module ffra_sched
  import ffra_sched_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_vld,
  input  logic            r1_vld,
  output logic            r0_rdy,
  output logic            r1_rdy,
  input  logic [A_W-1:0]  r0_a,
  input  logic [A_W-1:0]  r1_a,
  input  logic [A_W-1:0]  r0_b,
  input  logic [A_W-1:0]  r1_b,
  input  logic [CI_W-1:0] r0_ci,
  input  logic [CI_W-1:0] r1_ci,
  input  logic            r0_acc,
  input  logic            r1_acc,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic            rsp_id,
  output logic [O_W-1:0]  rsp_o,
  output logic [A_W-1:0]  dp_a,
  output logic [A_W-1:0]  dp_b,
  output logic [CI_W-1:0] dp_ci,
  input  logic [O_W-1:0]  dp_o,
  output logic            busy
);

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [A_W-1:0]  dp_a_q;
  logic [A_W-1:0]  dp_b_q;
  logic [CI_W-1:0] dp_ci_q;
  logic            rsp_vld_q;
  req_id_t         rsp_id_q;
  logic [O_W-1:0]  rsp_o_q;
  logic [O_W-1:0]  acc_q [2];

  logic [1:0]      gnt;
  logic            idle;
  req_id_t         gnt_id;
  req_t            req_sel;
  logic [CI_W-1:0] ci_sel;

  assign idle = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .vld_i    ({r1_vld, r0_vld}),
    .accept_i (idle),
    .gnt_o    (gnt)
  );

  assign r0_rdy = idle & gnt[0];
  assign r1_rdy = idle & gnt[1];

  // Operand mux: an accumulate request replaces its addend with that requester's last result.
  always_comb begin
    gnt_id  = gnt[1];
    req_sel = gnt_id ? '{a: r1_a, b: r1_b, ci: r1_ci, acc: r1_acc}
                     : '{a: r0_a, b: r0_b, ci: r0_ci, acc: r0_acc};
    ci_sel  = req_sel.acc ? acc_q[gnt_id] : req_sel.ci;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dp_a_q    <= '0;
      dp_b_q    <= '0;
      dp_ci_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_o_q   <= '0;
      // NOTE: the accumulator file is only two words and must read zero after reset, so it is reset.
      for (int i = 0; i < 2; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            dp_a_q   <= req_sel.a;
            dp_b_q   <= req_sel.b;
            dp_ci_q  <= ci_sel;
            rsp_id_q <= gnt_id;
            cnt_q    <= CNT_W'(LAT);
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Counter value 1 marks the edge at which dp_o has had LAT cycles to settle.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rsp_o_q   <= dp_o;
            rsp_vld_q <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_rdy) begin
            acc_q[rsp_id_q] <= rsp_o_q;
            rsp_vld_q       <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dp_a    = dp_a_q;
  assign dp_b    = dp_b_q;
  assign dp_ci   = dp_ci_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_o   = rsp_o_q;
  assign busy    = !idle;

endmodule
